// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: instruction-cache ports x/y, branch redirect, and decoder queue head.
interface inst_fetch_if;
  logic        en_rx;
  logic [31:0] pcx;
  logic        hitx;
  logic [31:0] instx;
  logic        en_ry;
  logic [31:0] pcy;
  logic        hity;
  logic [31:0] insty;
  logic        jump_en;
  logic [31:0] jump_pc;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_ready;

  modport master (
    output en_rx, pcx, en_ry, pcy, iq_valid, iq_inst, iq_pc,
    input  hitx, instx, hity, insty, jump_en, jump_pc, iq_ready
  );

  modport slave (
    input  en_rx, pcx, en_ry, pcy, iq_valid, iq_inst, iq_pc,
    output hitx, instx, hity, insty, jump_en, jump_pc, iq_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: IDLE/REQ/RESP fetch FSM feeding a DEPTH-entry instruction queue.
// Define FETCH_PAIR_EN for dual-port (x/y) issue; otherwise only port x is used.
`ifndef NULL_PTR
`define NULL_PTR 32'h0
`endif

module inst_fetch #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  inst_fetch_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef FETCH_PAIR_EN
  localparam int unsigned NEED = 2;
`else
  localparam int unsigned NEED = 1;
`endif

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];

  logic [CW-1:0]   free_slots;
  logic            issue;
  logic            resp_ok;
  logic            push_x;
  logic            push_y;
  logic            pop;
  logic            nonempty;

  always_comb begin
    free_slots = CW'(DEPTH) - count;
    nonempty   = (count != '0);
    // Space for the whole issue is reserved up front, so pushes never overflow.
    issue      = rdy && (state == REQ) && (free_slots >= CW'(NEED));
    resp_ok    = rdy && (state == RESP) && !bus.jump_en;
    push_x     = resp_ok && bus.hitx;
`ifdef FETCH_PAIR_EN
    push_y     = push_x && bus.hity;
`else
    push_y     = 1'b0;
`endif
    pop        = rdy && !bus.jump_en && nonempty && bus.iq_ready;
  end

`ifndef FETCH_PAIR_EN
  logic unused_y;
  assign unused_y = ^{bus.hity, bus.insty};
`endif

  always_comb begin
    bus.en_rx    = issue;
    bus.pcx      = issue ? pc : `NULL_PTR;
`ifdef FETCH_PAIR_EN
    bus.en_ry    = issue;
    bus.pcy      = issue ? (pc + 32'd4) : `NULL_PTR;
`else
    bus.en_ry    = 1'b0;
    bus.pcy      = `NULL_PTR;
`endif
    bus.iq_valid = nonempty;
    bus.iq_inst  = nonempty ? inst_mem[rd_ptr] : '0;
    bus.iq_pc    = nonempty ? pc_mem[rd_ptr]   : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (bus.jump_en) begin
        state  <= REQ;
        pc     <= bus.jump_pc;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        case (state)
          IDLE:    state <= REQ;
          REQ:     if (issue) state <= RESP;
          RESP:    state <= REQ;
          default: state <= IDLE;
        endcase
        if (push_x) pc <= pc + (push_y ? 32'd8 : 32'd4);
        wr_ptr <= wr_ptr + AW'(push_x) + AW'(push_y);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count  <= count + CW'(push_x) + CW'(push_y) - CW'(pop);
      end
    end else if (state == RESP) begin
      // A response pending across a stall is dropped; the same pc is re-requested.
      state <= REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (push_x) begin
      inst_mem[wr_ptr] <= bus.instx;
      pc_mem[wr_ptr]   <= pc;
    end
    if (push_y) begin
      inst_mem[wr_ptr + AW'(1)] <= bus.insty;
      pc_mem[wr_ptr + AW'(1)]   <= pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a registered-hit instruction-cache model.
`ifndef NULL_PTR
`define NULL_PTR 32'h0
`endif

module tb_inst_fetch;

`ifdef FETCH_PAIR_EN
  localparam bit PAIR = 1'b1;
`else
  localparam bit PAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic const_data;
  int   miss_target;
  int   miss_done;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(.DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  // Cache: hit/data registered one cycle after the request; first miss_target requests miss.
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.hitx  <= 1'b0;
      bus.hity  <= 1'b0;
      bus.instx <= '0;
      bus.insty <= '0;
      miss_done <= 0;
    end else begin
      if (bus.en_rx && miss_done < miss_target) begin
        bus.hitx  <= 1'b0;
        bus.hity  <= 1'b0;
        miss_done <= miss_done + 1;
      end else begin
        bus.hitx <= bus.en_rx;
        bus.hity <= bus.en_ry;
      end
      bus.instx <= const_data ? 32'h11 : ~bus.pcx;
      bus.insty <= const_data ? 32'h22 : ~bus.pcy;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    rdy            = 1'b0;
    bus.jump_en    = 1'b0;
    bus.jump_pc    = '0;
    bus.iq_ready   = 1'b0;
    miss_target    = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    rdy   = 1'b1;
  endtask

  initial begin
    int issues;
    int ry_ones;
    int last;
    int cyc;

    // Reset state
    const_data = 1'b1;
    do_reset();
    check("rst_iq_valid", 32'(bus.iq_valid), 32'd0);
    check("rst_iq_inst",  bus.iq_inst, 32'h0);
    check("rst_iq_pc",    bus.iq_pc,   32'h0);
    check("rst_en_rx",    32'(bus.en_rx), 32'd0);
    check("rst_en_ry",    32'(bus.en_ry), 32'd0);
    check("rst_pcx",      bus.pcx, `NULL_PTR);
    check("rst_pcy",      bus.pcy, `NULL_PTR);

    // First fetch after reset, constant cache data
    release_reset();
    @(negedge clk);
    check("a_no_push_first", 32'(bus.iq_valid), 32'd0);
    check("a_en_rx",  32'(bus.en_rx), 32'd1);
    check("a_pcx",    bus.pcx, 32'h0);
    check("a_en_ry",  32'(bus.en_ry), 32'(PAIR));
    check("a_pcy",    bus.pcy, PAIR ? 32'h4 : `NULL_PTR);
    @(negedge clk);
    check("a_resp_en_rx", 32'(bus.en_rx), 32'd0);
    check("a_resp_pcx",   bus.pcx, `NULL_PTR);
    @(negedge clk);
    check("a_head_valid", 32'(bus.iq_valid), 32'd1);
    check("a_head_pc",    bus.iq_pc, 32'h0);
    check("a_head_inst",  bus.iq_inst, 32'h11);
    check("a_next_pcx",   bus.pcx, PAIR ? 32'h8 : 32'h4);
`ifdef FETCH_PAIR_EN
    bus.iq_ready = 1'b1;
    @(negedge clk);
    check("a_second_pc",   bus.iq_pc, 32'h4);
    check("a_second_inst", bus.iq_inst, 32'h22);
    bus.iq_ready = 1'b0;
`endif

    // Miss retry: three misses at 0x100, then a hit
    const_data = 1'b0;
    do_reset();
    miss_target = 3;
    release_reset();
    bus.jump_en = 1'b1;
    bus.jump_pc = 32'h100;
    @(negedge clk);
    bus.jump_en = 1'b0;
    issues = 0;
    cyc    = 0;
    while (!bus.iq_valid && cyc < 40) begin
      if (bus.en_rx && bus.pcx == 32'h100) issues++;
      @(negedge clk);
      cyc++;
    end
    check("b_valid",       32'(bus.iq_valid), 32'd1);
    check("b_reissues",    32'(issues), 32'd4);
    check("b_push_cycle",  32'(cyc), 32'd8);
    check("b_first_pc",    bus.iq_pc, 32'h100);
    check("b_first_inst",  bus.iq_inst, 32'hFFFF_FEFF);

    // Fill queue with decoder stalled, then drain in order
    do_reset();
    release_reset();
    issues  = 0;
    ry_ones = 0;
    last    = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.en_rx) begin
        issues++;
        last = c;
      end
      if (bus.en_ry) ry_ones++;
    end
    check("c_issues",     32'(issues), PAIR ? 32'd4 : 32'd8);
    check("c_last_issue", 32'(last), PAIR ? 32'd7 : 32'd15);
    check("c_en_ry_count", 32'(ry_ones), PAIR ? 32'd4 : 32'd0);
    check("c_full_en_rx", 32'(bus.en_rx), 32'd0);
    check("c_full_valid", 32'(bus.iq_valid), 32'd1);
    bus.iq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("c_drain_pc%0d", i), bus.iq_pc, 32'(4 * i));
      check($sformatf("c_drain_inst%0d", i), bus.iq_inst, ~32'(4 * i));
      @(negedge clk);
    end
    bus.iq_ready = 1'b0;

    // Jump in the same cycle as a response hit
    do_reset();
    release_reset();
    repeat (4) @(negedge clk);
    check("d_pre_valid", 32'(bus.iq_valid), 32'd1);
    bus.jump_en = 1'b1;
    bus.jump_pc = 32'h200;
    @(negedge clk);
    bus.jump_en = 1'b0;
    check("d_flush_valid", 32'(bus.iq_valid), 32'd0);
    check("d_jump_en_rx",  32'(bus.en_rx), 32'd1);
    check("d_jump_pcx",    bus.pcx, 32'h200);
    repeat (2) @(negedge clk);
    check("d_after_pc",    bus.iq_pc, 32'h200);
    check("d_after_inst",  bus.iq_inst, ~32'h200);

    // Stall for five cycles while a response is due
    do_reset();
    release_reset();
    repeat (4) @(negedge clk);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("e_stall_en_rx%0d", k), 32'(bus.en_rx), 32'd0);
      check($sformatf("e_stall_head%0d", k), bus.iq_pc, 32'h0);
    end
    check("e_stall_valid", 32'(bus.iq_valid), 32'd1);
    rdy = 1'b1;
    #1;
    check("e_resume_en_rx", 32'(bus.en_rx), 32'd1);
    check("e_resume_pcx",   bus.pcx, PAIR ? 32'h8 : 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
